// File: rtl/counter_ir_cfg_ctrl.sv
// rtl/counter_ir_cfg_ctrl.sv - IR counter frontend config controller with pulse-safe commit
//
// Two requesters write a shadow register set through a round-robin write
// port. A commit (address 5) moves the FSM to PEND. The shadow set is copied
// to the active outputs only while both IR din pulses are idle. The copy is
// forced once the PEND wait reaches WAIT_MAX cycles.
//
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_reqN_vld/addr/wdata, o_reqN_gnt
//                                   requester N write port (N = 0 host, 1 sequencer)
//   i_din_a_act, i_din_b_act        frontend din pulses active
//   o_onecycle_value_a/b, o_din_bypass, o_dout_opts, o_dout_bypass
//                                   active configuration
//   o_cfg_pending                   high in PEND and APPLY
//   o_cfg_applied / o_cfg_forced    apply-cycle pulses
//   o_addr_err                      pulse, cycle after a granted write to addr 6/7

module counter_ir_cfg_ctrl #(
  parameter int          WAIT_MAX     = 1024,
  parameter logic [31:0] RST_ONECYCLE = 32'd100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_vld,
  input  logic [2:0]  i_req0_addr,
  input  logic [31:0] i_req0_wdata,
  output logic        o_req0_gnt,
  input  logic        i_req1_vld,
  input  logic [2:0]  i_req1_addr,
  input  logic [31:0] i_req1_wdata,
  output logic        o_req1_gnt,
  input  logic        i_din_a_act,
  input  logic        i_din_b_act,
  output logic [31:0] o_onecycle_value_a,
  output logic [31:0] o_onecycle_value_b,
  output logic [1:0]  o_din_bypass,
  output logic [7:0]  o_dout_opts,
  output logic [1:0]  o_dout_bypass,
  output logic        o_cfg_pending,
  output logic        o_cfg_applied,
  output logic        o_cfg_forced,
  output logic        o_addr_err
);

  // Counter only needs to reach WAIT_MAX-1; with WAIT_MAX = 0 it saturates.
  localparam int          CW         = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [CW-1:0] W_CNT_LAST = CW'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          w_force_next;
  logic          r_forced;
  logic [CW-1:0] r_cnt;
  logic          r_ptr;
  logic          r_addr_err;

  logic [31:0]   r_sh_a;
  logic [31:0]   r_sh_b;
  logic [1:0]    r_sh_din_byp;
  logic [7:0]    r_sh_opts;
  logic [1:0]    r_sh_dout_byp;

  logic [31:0]   r_act_a;
  logic [31:0]   r_act_b;
  logic [1:0]    r_act_din_byp;
  logic [7:0]    r_act_opts;
  logic [1:0]    r_act_dout_byp;

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_wr;
  logic [2:0]    w_addr;
  logic [31:0]   w_wdata;
  logic          w_commit;

  // Pointer holder wins a tie; a lone requester always wins.
  assign w_gnt0   = i_req0_vld & (~i_req1_vld | ~r_ptr);
  assign w_gnt1   = i_req1_vld & (~i_req0_vld |  r_ptr);
  assign w_wr     = w_gnt0 | w_gnt1;
  assign w_addr   = w_gnt0 ? i_req0_addr  : i_req1_addr;
  assign w_wdata  = w_gnt0 ? i_req0_wdata : i_req1_wdata;
  assign w_commit = w_wr & (w_addr == 3'd5);

  assign o_req0_gnt = w_gnt0;
  assign o_req1_gnt = w_gnt1;

  // Arbiter pointer, address-error pulse and shadow registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr         <= 1'b0;
      r_addr_err    <= 1'b0;
      r_sh_a        <= RST_ONECYCLE;
      r_sh_b        <= RST_ONECYCLE;
      r_sh_din_byp  <= 2'b11;
      r_sh_opts     <= 8'h00;
      r_sh_dout_byp <= 2'b11;
    end else begin
      r_addr_err <= w_wr & (w_addr[2:1] == 2'b11);
      if (w_gnt0) begin
        r_ptr <= 1'b1;
      end else if (w_gnt1) begin
        r_ptr <= 1'b0;
      end
      if (w_wr) begin
        case (w_addr)
          3'd0:    r_sh_a        <= w_wdata;
          3'd1:    r_sh_b        <= w_wdata;
          3'd2:    r_sh_din_byp  <= w_wdata[1:0];
          3'd3:    r_sh_opts     <= w_wdata[7:0];
          3'd4:    r_sh_dout_byp <= w_wdata[1:0];
          default: ;
        endcase
      end
    end
  end

  // FSM state, forced flag and PEND wait counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_forced <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_forced <= w_force_next;
      if (r_state == S_PEND) begin
        if (r_cnt != {CW{1'b1}}) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_force_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_commit) begin
          w_state_next = S_PEND;
        end
      end
      S_PEND: begin
        // A commit granted here is absorbed into the pending apply.
        if (!i_din_a_act && !i_din_b_act) begin
          w_state_next = S_APPLY;
        end else if ((WAIT_MAX != 0) && (r_cnt == W_CNT_LAST)) begin
          w_state_next = S_APPLY;
          w_force_next = 1'b1;
        end
      end
      S_APPLY: begin
        w_state_next = w_commit ? S_PEND : S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Active set copies the pre-edge shadow, so a write granted in the APPLY
  // cycle waits for the next commit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_act_a        <= RST_ONECYCLE;
      r_act_b        <= RST_ONECYCLE;
      r_act_din_byp  <= 2'b11;
      r_act_opts     <= 8'h00;
      r_act_dout_byp <= 2'b11;
    end else if (r_state == S_APPLY) begin
      r_act_a        <= r_sh_a;
      r_act_b        <= r_sh_b;
      r_act_din_byp  <= r_sh_din_byp;
      r_act_opts     <= r_sh_opts;
      r_act_dout_byp <= r_sh_dout_byp;
    end
  end

  assign o_onecycle_value_a = r_act_a;
  assign o_onecycle_value_b = r_act_b;
  assign o_din_bypass       = r_act_din_byp;
  assign o_dout_opts        = r_act_opts;
  assign o_dout_bypass      = r_act_dout_byp;
  assign o_cfg_pending      = (r_state != S_IDLE);
  assign o_cfg_applied      = (r_state == S_APPLY);
  assign o_cfg_forced       = (r_state == S_APPLY) & r_forced;
  assign o_addr_err         = r_addr_err;

endmodule
